// File: rtl/qvalue_pkg.sv
// Shared types and constants for the Q-value advertisement receive path.
package qvalue_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned AGE_WIDTH  = 8;

  localparam logic [WORD_WIDTH-1:0] PKT_TYPE_ADV = 16'h0001;

  typedef enum logic [2:0] {
    S_HDR,
    S_SRC,
    S_NRG,
    S_HOP,
    S_QV,
    S_UPDATE,
    S_SCAN
  } rx_state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] qvalue;
    logic                  valid;
    logic [AGE_WIDTH-1:0]  age;
  } nbr_entry_t;

endpackage

// File: rtl/qvalue_neighbor_select_nbr_table.sv
// Neighbour table: storage, ID-match lookup, hit-or-append write port and indexed read.
// Per-entry aging is compiled in with NEIGHBOR_AGING_EN.
module nbr_table
  import qvalue_pkg::*;
#(
  parameter int unsigned MAX_NEIGHBORS = 8,
  parameter int unsigned AGE_LIMIT     = 4,
  localparam int unsigned IDX_W = $clog2(MAX_NEIGHBORS),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  wrEn,
  input  nbr_entry_t            wrEntry,
  input  logic [WORD_WIDTH-1:0] lookupId,
  output logic                  hit,
  output logic [IDX_W-1:0]      hitIdx,
  input  logic [IDX_W-1:0]      rdIdx,
  output nbr_entry_t            rdEntry,
  output logic [CNT_W-1:0]      count
`ifdef NEIGHBOR_AGING_EN
  ,
  input  logic                  tick,
  output logic                  staleEvent
`endif
);

  nbr_entry_t        entries_q [MAX_NEIGHBORS];
  logic [CNT_W-1:0]  count_q;
  logic [IDX_W-1:0]  wrIdx;

  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = 0; i < MAX_NEIGHBORS; i++) begin
      if (!hit && entries_q[i].valid && entries_q[i].id == lookupId) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

  // A miss appends at the current count; the caller never writes a miss when full.
  assign wrIdx   = hit ? hitIdx : count_q[IDX_W-1:0];
  assign rdEntry = entries_q[rdIdx];
  assign count   = count_q;

`ifdef NEIGHBOR_AGING_EN
  always_comb begin
    staleEvent = 1'b0;
    for (int i = 0; i < MAX_NEIGHBORS; i++) begin
      if (tick && entries_q[i].valid && entries_q[i].age == AGE_WIDTH'(AGE_LIMIT - 1) &&
          !(wrEn && wrIdx == IDX_W'(i))) begin
        staleEvent = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      entries_q <= '{default: '0};
      count_q   <= '0;
    end else if (clear) begin
      entries_q <= '{default: '0};
      count_q   <= '0;
    end else begin
`ifdef NEIGHBOR_AGING_EN
      if (tick) begin
        for (int i = 0; i < MAX_NEIGHBORS; i++) begin
          if (entries_q[i].valid && entries_q[i].age < AGE_WIDTH'(AGE_LIMIT)) begin
            entries_q[i].age <= entries_q[i].age + AGE_WIDTH'(1);
          end
        end
      end
`endif
      // Whole-entry write lands after the age bump, so a refresh wins over a tick.
      if (wrEn) begin
        entries_q[wrIdx] <= wrEntry;
        if (!hit) count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/qvalue_neighbor_select.sv
// Parses neighbour adverts, maintains the table and rescans it for best Q and energy range.
// Optional NEIGHBOR_AGING_EN adds a tick input that ages entries out of the scan.
module qvalue_neighbor_select #(
  parameter int unsigned WORD_WIDTH    = qvalue_pkg::WORD_WIDTH,
  parameter int unsigned MAX_NEIGHBORS = 8,
  parameter int unsigned AGE_LIMIT     = 4,
  localparam int unsigned IDX_W = $clog2(MAX_NEIGHBORS),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [WORD_WIDTH-1:0] bestNeighbor,
  output logic [WORD_WIDTH-1:0] bestQValue,
  output logic                  best_valid,
  output logic [WORD_WIDTH-1:0] minEnergy,
  output logic [WORD_WIDTH-1:0] maxEnergy,
  output logic [CNT_W-1:0]      neighborCount,
  output logic                  pkt_drop,
  output logic                  update_done
`ifdef NEIGHBOR_AGING_EN
  ,
  input  logic                  tick
`endif
);
  import qvalue_pkg::*;

  rx_state_t             state_q, state_d;
  logic [WORD_WIDTH-1:0] srcId_q, energy_q, hops_q, qv_q;
  logic [IDX_W-1:0]      scanIdx_q, hitIdx;
  logic                  accFound_q;
  logic [WORD_WIDTH-1:0] accBestId_q, accBestQ_q, accMinE_q, accMaxE_q;
  logic                  accept, hit, full, dropNow, wrEn, lastScan, scanStart, idleScan;
  logic                  eligible, foldFound;
  logic [WORD_WIDTH-1:0] foldId, foldQ, foldMinE, foldMaxE;
  logic [CNT_W-1:0]      count;
  nbr_entry_t            wrEntry, rdEntry;

`ifdef NEIGHBOR_AGING_EN
  logic staleEvent, agingPend_q;
  assign idleScan = (state_q == S_HDR) && agingPend_q;
  assign eligible = rdEntry.valid && (rdEntry.age != AGE_WIDTH'(AGE_LIMIT));
`else
  assign idleScan = 1'b0;
  assign eligible = rdEntry.valid;
`endif

  assign rx_ready      = (state_q inside {S_HDR, S_SRC, S_NRG, S_HOP, S_QV}) && !idleScan;
  assign accept        = rx_valid && rx_ready;
  assign full          = (count == CNT_W'(MAX_NEIGHBORS));
  assign dropNow       = (srcId_q == myNodeID) || (!hit && full);
  assign wrEn          = (state_q == S_UPDATE) && !dropNow && !flush;
  assign scanStart     = idleScan || ((state_q == S_UPDATE) && !dropNow);
  assign lastScan      = ({1'b0, scanIdx_q} + CNT_W'(1)) >= count;
  assign neighborCount = count;

  always_comb begin
    wrEntry        = '0;
    wrEntry.id     = srcId_q;
    wrEntry.energy = energy_q;
    wrEntry.hops   = hops_q;
    wrEntry.qvalue = qv_q;
    wrEntry.valid  = 1'b1;
  end

  nbr_table #(
    .MAX_NEIGHBORS(MAX_NEIGHBORS),
    .AGE_LIMIT    (AGE_LIMIT)
  ) u_table (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (flush),
    .wrEn      (wrEn),
    .wrEntry   (wrEntry),
    .lookupId  (srcId_q),
    .hit       (hit),
    .hitIdx    (hitIdx),
    .rdIdx     (scanIdx_q),
    .rdEntry   (rdEntry),
    .count     (count)
`ifdef NEIGHBOR_AGING_EN
    ,
    .tick      (tick),
    .staleEvent(staleEvent)
`endif
  );

  // Fold the visited entry into the running results; strict '>' keeps the lower index on ties.
  always_comb begin
    foldFound = accFound_q || eligible;
    foldId    = accBestId_q;
    foldQ     = accBestQ_q;
    foldMinE  = accMinE_q;
    foldMaxE  = accMaxE_q;
    if (eligible && !accFound_q) begin
      foldId   = rdEntry.id;
      foldQ    = rdEntry.qvalue;
      foldMinE = rdEntry.energy;
      foldMaxE = rdEntry.energy;
    end else if (eligible) begin
      if (rdEntry.qvalue > accBestQ_q) begin
        foldId = rdEntry.id;
        foldQ  = rdEntry.qvalue;
      end
      if (rdEntry.energy < accMinE_q) foldMinE = rdEntry.energy;
      if (rdEntry.energy > accMaxE_q) foldMaxE = rdEntry.energy;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR: begin
        if (idleScan) state_d = S_SCAN;
        else if (accept && rx_data == PKT_TYPE_ADV) state_d = S_SRC;
      end
      S_SRC:    if (accept) state_d = S_NRG;
      S_NRG:    if (accept) state_d = S_HOP;
      S_HOP:    if (accept) state_d = S_QV;
      S_QV:     if (accept) state_d = S_UPDATE;
      S_UPDATE: state_d = dropNow ? S_HDR : S_SCAN;
      S_SCAN:   if (lastScan) state_d = S_HDR;
      default:  state_d = S_HDR;
    endcase
    if (flush) state_d = S_HDR;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_HDR;
    else       state_q <= state_d;
  end

`ifdef NEIGHBOR_AGING_EN
  // Set beats clear so a tick landing on a scan start still earns a follow-up rescan.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)           agingPend_q <= 1'b0;
    else if (flush)      agingPend_q <= 1'b0;
    else if (staleEvent) agingPend_q <= 1'b1;
    else if (scanStart)  agingPend_q <= 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst || flush) begin
      if (!nrst) begin
        srcId_q  <= '0;
        energy_q <= '0;
        hops_q   <= '0;
        qv_q     <= '0;
      end
      scanIdx_q    <= '0;
      accFound_q   <= 1'b0;
      accBestId_q  <= '0;
      accBestQ_q   <= '0;
      accMinE_q    <= '0;
      accMaxE_q    <= '0;
      bestNeighbor <= '0;
      bestQValue   <= '0;
      best_valid   <= 1'b0;
      minEnergy    <= '0;
      maxEnergy    <= '0;
      pkt_drop     <= 1'b0;
      update_done  <= 1'b0;
    end else begin
      pkt_drop    <= 1'b0;
      update_done <= 1'b0;
      if (accept && state_q == S_SRC) srcId_q  <= rx_data;
      if (accept && state_q == S_NRG) energy_q <= rx_data;
      if (accept && state_q == S_HOP) hops_q   <= rx_data;
      if (accept && state_q == S_QV)  qv_q     <= rx_data;
      if (state_q == S_UPDATE) pkt_drop <= dropNow;
      if (scanStart) begin
        scanIdx_q  <= '0;
        accFound_q <= 1'b0;
      end
      if (state_q == S_SCAN) begin
        scanIdx_q   <= scanIdx_q + IDX_W'(1);
        accFound_q  <= foldFound;
        accBestId_q <= foldId;
        accBestQ_q  <= foldQ;
        accMinE_q   <= foldMinE;
        accMaxE_q   <= foldMaxE;
        if (lastScan) begin
          bestNeighbor <= foldFound ? foldId   : '0;
          bestQValue   <= foldFound ? foldQ    : '0;
          minEnergy    <= foldFound ? foldMinE : '0;
          maxEnergy    <= foldFound ? foldMaxE : '0;
          best_valid   <= foldFound;
          update_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qvalue_neighbor_select.sv
// Randomized self-checking bench for qvalue_neighbor_select against a queue-based table model.
module tb_qvalue_neighbor_select;

  logic        clk = 1'b0;
  logic        nrst, flush, rx_valid, rx_ready, best_valid, pkt_drop, update_done;
  logic [15:0] myNodeID, rx_data, bestNeighbor, bestQValue, minEnergy, maxEnergy;
  logic [3:0]  neighborCount;
`ifdef NEIGHBOR_AGING_EN
  logic        tick = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int doneCnt = 0;

  logic [15:0] mId[$];
  logic [15:0] mNrg[$];
  logic [15:0] mQ[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (update_done) doneCnt++;

  qvalue_neighbor_select dut (
    .clk          (clk),
    .nrst         (nrst),
    .flush        (flush),
    .myNodeID     (myNodeID),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .bestNeighbor (bestNeighbor),
    .bestQValue   (bestQValue),
    .best_valid   (best_valid),
    .minEnergy    (minEnergy),
    .maxEnergy    (maxEnergy),
    .neighborCount(neighborCount),
    .pkt_drop     (pkt_drop),
    .update_done  (update_done)
`ifdef NEIGHBOR_AGING_EN
    ,
    .tick         (tick)
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs straight from the table contents: highest Q, first index wins ties.
  task automatic checkOutputs(input string tag);
    logic [15:0] bId, bQ, mn, mx;
    logic        found;
    bId = '0; bQ = '0; mn = '0; mx = '0; found = 1'b0;
    for (int i = 0; i < mId.size(); i++) begin
      if (!found || mQ[i] > bQ) begin
        bId = mId[i];
        bQ  = mQ[i];
      end
      if (!found || mNrg[i] < mn) mn = mNrg[i];
      if (!found || mNrg[i] > mx) mx = mNrg[i];
      found = 1'b1;
    end
    checkEq({tag, ".best"},  32'(bestNeighbor),  32'(bId));
    checkEq({tag, ".q"},     32'(bestQValue),    32'(bQ));
    checkEq({tag, ".valid"}, 32'(best_valid),    32'(found));
    checkEq({tag, ".min"},   32'(minEnergy),     32'(mn));
    checkEq({tag, ".max"},   32'(maxEnergy),     32'(mx));
    checkEq({tag, ".count"}, 32'(neighborCount), 32'(mId.size()));
  endtask

  task automatic sendWord(input logic [15:0] w, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = w;
    rx_valid = 1'b1;
    for (int k = 0; k < 20 && !rx_ready; k++) @(negedge clk);
    if (!rx_ready) checkEq("ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic sendAdvert(input string tag, input logic [15:0] src, input logic [15:0] nrg,
                            input logic [15:0] q, input int maxGap);
    logic [15:0] w[5];
    int          idx, lat;
    logic        expDrop, gotDrop;
    w[0] = 16'h0001; w[1] = src; w[2] = nrg; w[3] = 16'($urandom_range(0, 15)); w[4] = q;
    for (int i = 0; i < 5; i++) sendWord(w[i], (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
    idx = -1;
    for (int i = 0; i < mId.size(); i++) if (mId[i] == src) idx = i;
    expDrop = 1'b0;
    if (src == myNodeID) expDrop = 1'b1;
    else if (idx >= 0) begin
      mNrg[idx] = nrg;
      mQ[idx]   = q;
    end else if (mId.size() < 8) begin
      mId.push_back(src);
      mNrg.push_back(nrg);
      mQ.push_back(q);
    end else expDrop = 1'b1;
    lat = 0;
    gotDrop = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (update_done || pkt_drop) begin
        lat     = k;
        gotDrop = pkt_drop;
        break;
      end
    end
    checkEq({tag, ".drop"}, 32'(gotDrop), 32'(expDrop));
    checkEq({tag, ".lat"},  32'(lat), expDrop ? 32'd2 : 32'(mId.size() + 2));
    checkOutputs(tag);
    @(negedge clk);
    checkEq({tag, ".pulse"}, 32'({update_done, pkt_drop}), 32'd0);
  endtask

  task automatic doFlush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mId.delete(); mNrg.delete(); mQ.delete();
  endtask

  initial begin
    int d0;
    nrst = 1'b0; flush = 1'b0; rx_valid = 1'b0; rx_data = '0; myNodeID = 16'h0001;
    repeat (3) @(negedge clk);
    checkOutputs("reset");
    checkEq("reset.drop_done", 32'({pkt_drop, update_done}), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    checkEq("reset.ready", 32'(rx_ready), 32'd1);

    sendAdvert("adv1", 16'h0007, 16'h8000, 16'h4000, 0);
    checkEq("adv1.bestId", 32'(bestNeighbor), 32'h0007);
    sendAdvert("adv2", 16'h0009, 16'h4000, 16'h6000, 0);
    sendAdvert("readv9", 16'h0009, 16'h4000, 16'h2000, 0);
    checkEq("readv9.bestId", 32'(bestNeighbor), 32'h0007);
    sendAdvert("tieA", 16'h000A, 16'h5000, 16'h4000, 0);
    for (int i = 0; i < 5; i++)
      sendAdvert("fill", 16'(16'h0010 + i), 16'($urandom_range(1, 16'hffff)),
                 16'($urandom_range(0, 16'h3fff)), 1);
    sendAdvert("full", 16'h0020, 16'h1234, 16'hffff, 0);
    sendAdvert("self", 16'h0001, 16'h1234, 16'hffff, 0);

    // Junk header, then a packet with gaps aborted by flush while in S_HOP.
    d0 = doneCnt;
    sendWord(16'h0005, 0);
    sendWord(16'h0001, 1);
    sendWord(16'h0030, 2);
    sendWord(16'h0100, 1);
    doFlush();
    checkOutputs("flush");
    repeat (10) @(negedge clk);
    checkEq("flush.noDone", 32'(doneCnt), 32'(d0));
    sendAdvert("postFlush", 16'h0031, 16'h0200, 16'h0300, 0);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] src;
      if ($urandom_range(0, 11) == 0) begin
        doFlush();
        checkOutputs("rndFlush");
      end
      src = ($urandom_range(0, 9) == 0) ? myNodeID : 16'($urandom_range(2, 13));
      sendAdvert("rnd", src, 16'(16'h1000 * $urandom_range(1, 8)),
                 16'(16'h1000 * $urandom_range(1, 4)), 2);
    end

`ifdef NEIGHBOR_AGING_EN
    doFlush();
    sendAdvert("age7", 16'h0007, 16'h8000, 16'h4000, 0);
    sendAdvert("age9", 16'h0009, 16'h4000, 16'h6000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
    sendAdvert("ageRefresh7", 16'h0007, 16'h8000, 16'h4000, 0);
    d0 = doneCnt;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int k = 0; k < 20 && doneCnt == d0; k++) @(negedge clk);
    checkEq("aging.rescan", 32'(doneCnt - d0), 32'd1);
    checkEq("aging.best",  32'(bestNeighbor),  32'h0007);
    checkEq("aging.q",     32'(bestQValue),    32'h4000);
    checkEq("aging.min",   32'(minEnergy),     32'h8000);
    checkEq("aging.max",   32'(maxEnergy),     32'h8000);
    checkEq("aging.count", 32'(neighborCount), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
